// File: rtl/pn_seq_gen.sv
// pn_seq_gen -- pseudo-noise (m-sequence) chip generator.
//
// A Fibonacci LFSR advances once per rising edge of a rate reference chosen
// from the clock divider's level outputs. Each step emits one chip with a
// valid strobe, a frame-sync strobe on chip index 0, and the chip index.
// The divider outputs are sampled as synchronous levels in the clk domain.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-high reset
//   div_in     divider levels {/256, /16, /8, /2}, bit0 = /2
//   rate_sel   selects div_in[rate_sel] as the chip-rate reference
//   en         1 = advance on ticks, 0 = hold (ticks discarded)
//   seed_load  single-cycle request to load seed into the LFSR
//   seed       LFSR load value (all-zero is replaced by all-ones)
//   pn_out     current chip, registered
//   pn_valid   one-cycle strobe: new chip on pn_out
//   frame_sync one-cycle strobe with pn_valid for chip index 0
//   chip_idx   index of the chip on pn_out, 0 .. 2^N-2
//   lockup     sticky flag: an all-zero seed was replaced
module pn_seq_gen #(
  parameter int unsigned    N    = 7,
  parameter logic [N-1:0]   POLY = 7'b1100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   div_in,
  input  logic [1:0]   rate_sel,
  input  logic         en,
  input  logic         seed_load,
  input  logic [N-1:0] seed,
  output logic         pn_out,
  output logic         pn_valid,
  output logic         frame_sync,
  output logic [N-1:0] chip_idx,
  output logic         lockup
);

  localparam logic [N-1:0] LAST_IDX = N'((2 ** N) - 2);

  logic [N-1:0] state;
  logic [N-1:0] next_idx;
  logic         ref_q;
  logic         ref_d;
  logic [1:0]   rate_q;

  logic         sel_ref;
  logic         rate_chg;
  logic         tick;
  logic         step;
  logic         fb;

  always_comb begin
    sel_ref  = div_in[rate_sel];
    rate_chg = (rate_sel != rate_q);
    tick     = ref_q & ~ref_d & ~rate_chg;
    step     = tick & en & ~seed_load;
    fb       = ^(state & POLY);
  end

  // Rate detector. On a reference swap both history taps take the newly
  // selected sample, so the edge detector sees no transition across the swap;
  // copying the old ref_q into ref_d would let the old/new level difference
  // appear as a spurious rising edge one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q  <= 1'b0;
      ref_d  <= 1'b0;
      rate_q <= '0;
    end else begin
      rate_q <= rate_sel;
      ref_q  <= sel_ref;
      ref_d  <= rate_chg ? sel_ref : ref_q;
    end
  end

  // LFSR, chip output and strobes. A seed load takes priority over a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= '1;
      next_idx   <= '0;
      pn_out     <= 1'b0;
      pn_valid   <= 1'b0;
      frame_sync <= 1'b0;
      chip_idx   <= '0;
      lockup     <= 1'b0;
    end else begin
      pn_valid   <= 1'b0;
      frame_sync <= 1'b0;
      if (seed_load) begin
        next_idx <= '0;
        if (seed == '0) begin
          state  <= '1;
          lockup <= 1'b1;
        end else begin
          state <= seed;
        end
      end else if (step) begin
        pn_out     <= state[N-1];
        state      <= {state[N-2:0], fb};
        chip_idx   <= next_idx;
        next_idx   <= (next_idx == LAST_IDX) ? '0 : next_idx + 1'b1;
        pn_valid   <= 1'b1;
        frame_sync <= (next_idx == '0);
      end
    end
  end

endmodule

// File: tb/tb_pn_seq_gen.sv
// Testbench for pn_seq_gen: directed test-plan steps followed by a randomized
// phase, every cycle checked against a reference model that predicts strobes
// from the history of sampled reference levels and chips from the m-sequence
// recurrence c[j] = XOR of POLY-selected earlier chips.
module tb_pn_seq_gen;

  localparam int unsigned N      = 7;
  localparam logic [6:0]  POLY   = 7'b1100000;
  localparam int          PERIOD = 127;

  logic       clk;
  logic       rst;
  logic [3:0] div_in;
  logic [1:0] rate_sel;
  logic       en;
  logic       seed_load;
  logic [6:0] seed;
  logic       pn_out;
  logic       pn_valid;
  logic       frame_sync;
  logic [6:0] chip_idx;
  logic       lockup;

  pn_seq_gen #(.N(N), .POLY(POLY)) dut (
    .clk(clk), .rst(rst), .div_in(div_in), .rate_sel(rate_sel), .en(en),
    .seed_load(seed_load), .seed(seed), .pn_out(pn_out), .pn_valid(pn_valid),
    .frame_sync(frame_sync), .chip_idx(chip_idx), .lockup(lockup)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [7:0] div_cnt = '0;

  // reference model
  bit seq [0:PERIOD-1];
  int pos;
  bit m_pn, m_valid, m_frame, m_lock;
  int m_idx;
  bit s1, s2;          // selected reference sample at the previous two edges
  logic [1:0] r1, r2;  // rate_sel at the previous two edges

  // DUT observations
  bit chips [$];
  int vt [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chip sequence starting from LFSR state st: the first N chips are the
  // state bits MSB first, later chips follow the tap recurrence.
  task automatic gen_seq(input logic [6:0] st);
    for (int j = 0; j < PERIOD; j++) begin
      if (j < 7) seq[j] = st[6-j];
      else begin
        bit b = 1'b0;
        for (int i = 0; i < 7; i++) if (POLY[i]) b ^= seq[j-1-i];
        seq[j] = b;
      end
    end
  endtask

  task automatic model_reset();
    m_pn = 0; m_valid = 0; m_frame = 0; m_lock = 0; m_idx = 0; pos = 0;
    s1 = 0; s2 = 0; r1 = 2'd0; r2 = 2'd0;
    gen_seq(7'h7f);
  endtask

  function automatic bit will_tick();
    return (rate_sel == r1) && (r1 == r2) && s1 && !s2;
  endfunction

  task automatic model_edge();
    bit t;
    if (rst) begin
      model_reset();
      return;
    end
    t = will_tick() && en && !seed_load;
    m_valid = 0; m_frame = 0;
    if (seed_load) begin
      if (seed == 7'd0) begin gen_seq(7'h7f); m_lock = 1; end
      else gen_seq(seed);
      pos = 0;
    end else if (t) begin
      m_pn = seq[pos]; m_idx = pos; m_frame = (pos == 0); m_valid = 1;
      pos = (pos + 1) % PERIOD;
    end
    s2 = s1; s1 = div_in[rate_sel];
    r2 = r1; r1 = rate_sel;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    div_cnt++;
    div_in = {div_cnt[7], div_cnt[3], div_cnt[2], div_cnt[0]};
    cyc++;
    @(negedge clk);
    chk("pn_valid", 32'(pn_valid), 32'(m_valid));
    chk("frame_sync", 32'(frame_sync), 32'(m_frame));
    chk("pn_out", 32'(pn_out), 32'(m_pn));
    chk("chip_idx", 32'(chip_idx), 32'(m_idx));
    chk("lockup", 32'(lockup), 32'(m_lock));
    if (pn_valid === 1'b1) begin
      chips.push_back(pn_out);
      vt.push_back(cyc);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int ones, frames, k;
    bit got;
    logic saved_pn;
    logic [6:0] saved_idx;
    logic [7:0] pat;

    rst = 1'b1; div_in = '0; rate_sel = 2'd0; en = 1'b0;
    seed_load = 1'b0; seed = '0;
    model_reset();
    run(3);
    chk("rst_pn_out", 32'(pn_out), 0);
    chk("rst_chip_idx", 32'(chip_idx), 0);
    rst = 1'b0; en = 1'b1;

    // default sequence at /2
    chips.delete(); vt.delete();
    run(300);
    chk("n_chips", 32'(chips.size() >= 134), 1);
    if (chips.size() >= 134) begin
      for (int i = 0; i < 7; i++) chk("first_ones", 32'(chips[i]), 1);
      chk("chip7", 32'(chips[7]), 0);
      ones = 0;
      for (int i = 0; i < PERIOD; i++) ones += chips[i];
      chk("period_ones", ones, 64);
      for (int i = 127; i < 134; i++) chk("wrap_ones", 32'(chips[i]), 1);
    end
    for (int i = 1; i < vt.size(); i++) chk("gap2", vt[i] - vt[i-1], 2);

    // switch to /256 mid-run
    rate_sel = 2'd3;
    vt.delete();
    run(1100);
    chk("n_256", 32'(vt.size() >= 3), 1);
    for (int i = 1; i < vt.size(); i++) chk("gap256", vt[i] - vt[i-1], 256);

    // all-zero seed is replaced and flagged
    seed = 7'd0; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    chk("lockup_set", 32'(lockup), 1);
    rate_sel = 2'd0;
    chips.delete();
    run(30);
    chk("n_after_seed0", 32'(chips.size() >= 8), 1);
    if (chips.size() >= 8) begin
      pat = 8'b11111110;
      for (int i = 0; i < 8; i++) chk("seed0_chips", 32'(chips[i]), 32'(pat[7-i]));
    end

    // seed load colliding with a tick
    k = 0;
    while (!will_tick() && k < 10) begin cycle(); k++; end
    chk("tick_found", 32'(will_tick()), 1);
    seed = 7'b0000001; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    chk("collide_no_valid", 32'(pn_valid), 0);
    got = 0; k = 0;
    while (!got && k < 10) begin
      cycle(); k++;
      if (pn_valid === 1'b1) got = 1;
    end
    chk("collide_strobe", 32'(got), 1);
    chk("collide_pn", 32'(pn_out), 0);
    chk("collide_idx", 32'(chip_idx), 0);
    chk("collide_frame", 32'(frame_sync), 1);
    run(20);

    // en low holds everything
    en = 1'b0;
    saved_pn = pn_out; saved_idx = chip_idx;
    chips.delete();
    run(40);
    chk("en0_no_strobe", chips.size(), 0);
    chk("en0_pn_hold", 32'(pn_out), 32'(saved_pn));
    chk("en0_idx_hold", 32'(chip_idx), 32'(saved_idx));
    en = 1'b1;
    run(25);
    chk("lockup_sticky", 32'(lockup), 1);

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_pn_out", 32'(pn_out), 0);
    chk("arst_valid", 32'(pn_valid), 0);
    chk("arst_frame", 32'(frame_sync), 0);
    chk("arst_idx", 32'(chip_idx), 0);
    chk("arst_lockup", 32'(lockup), 0);
    cycle();
    rst = 1'b0;
    chips.delete();
    run(20);
    chk("n_after_rst", 32'(chips.size() >= 7), 1);
    if (chips.size() >= 7)
      for (int i = 0; i < 7; i++) chk("rst_restart", 32'(chips[i]), 1);

    // randomized traffic
    frames = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) rate_sel = 2'($urandom_range(3));
      else if (rate_sel == 2'd3 && $urandom_range(299) == 0) rate_sel = 2'd0;
      en = ($urandom_range(7) != 0);
      seed_load = ($urandom_range(63) == 0);
      seed = ($urandom_range(3) == 0) ? 7'd0 : 7'($urandom);
      cycle();
      if (frame_sync === 1'b1) frames++;
    end
    seed_load = 1'b0;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
